fp_row_accumulator: RTL and testbench

Downstream consumer of the FP32 partial-product multiplier in the GUST SpMV datapath. Accepts a stream of single-precision partial products, each tagged with its destination row, and sums them with an internal single-cycle FP32 adder until the product marked last for that row arrives. It then presents the row sum, row index and product count on a one-entry valid/ready output buffer for the result write-back stage.

---
 rtl/fp_row_accumulator_if.sv | 29 ++
 rtl/fp_row_accumulator.sv | 165 ++++++++++++++++
 tb/tb_fp_row_accumulator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fp_row_accumulator_if.sv
// Stream bundle between the partial-product source, the row accumulator and
// the result write-back stage.
interface fp_row_accumulator_if #(
   parameter int unsigned value_size = 32,
   parameter int unsigned row_bits   = 16,
   parameter int unsigned cnt_bits   = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [value_size-1:0] in_pprod;
   logic [row_bits-1:0]   in_row;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [value_size-1:0] out_sum;
   logic [row_bits-1:0]   out_row;
   logic [cnt_bits-1:0]   out_count;
   logic                  err;

   modport master (
      output in_valid, in_pprod, in_row, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_row, out_count, err
   );

   modport slave (
      input  in_valid, in_pprod, in_row, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_row, out_count, err
   );
endinterface

// File: rtl/fp_row_accumulator.sv
// Sums row-tagged FP32 partial products with a single-cycle truncating adder
// and hands each finished row to a one-entry valid/ready output buffer.
module fp_row_accumulator #(
   parameter int unsigned value_size = 32,
   parameter int unsigned row_bits   = 16,
   parameter int unsigned cnt_bits   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   fp_row_accumulator_if.slave   bus
);

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   state_t                state_q, state_d;
   logic [value_size-1:0] acc_q, acc_d;
   logic [row_bits-1:0]   acc_row_q, acc_row_d;
   logic [cnt_bits-1:0]   acc_cnt_q, acc_cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic [value_size-1:0] out_sum_q, out_sum_d;
   logic [row_bits-1:0]   out_row_q, out_row_d;
   logic [cnt_bits-1:0]   out_count_q, out_count_d;
   logic                  err_q, err_d;

   logic                  in_ready;
   logic                  accept;
   logic [value_size-1:0] acc_next;
   logic [cnt_bits-1:0]   cnt_next;

   // Denormals flush to zero, alignment truncates, and any zero result is +0.0.
   function automatic logic [31:0] fpadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]       a, b;
      logic [30:0]       mag_x, mag_y;
      logic [23:0]       sig_a, sig_b, dif, mant;
      logic [24:0]       sum;
      logic [7:0]        diff;
      logic signed [9:0] exp_r;
      logic [4:0]        lz;
      logic              found;
      mag_x = (x[30:23] == 8'd0) ? '0 : x[30:0];
      mag_y = (y[30:23] == 8'd0) ? '0 : y[30:0];
      if (mag_x >= mag_y) begin
         a = x;
         b = y;
      end else begin
         a = y;
         b = x;
      end
      if (a[30:23] == 8'd0) return '0;
      sig_a = {1'b1, a[22:0]};
      sig_b = (b[30:23] == 8'd0) ? '0 : {1'b1, b[22:0]};
      diff  = a[30:23] - b[30:23];
      sig_b = (diff >= 8'd24) ? '0 : (sig_b >> diff);
      exp_r = signed'({2'b00, a[30:23]});
      mant  = '0;
      sum   = '0;
      dif   = '0;
      lz    = '0;
      found = 1'b0;
      if (a[31] == b[31]) begin
         sum = {1'b0, sig_a} + {1'b0, sig_b};
         if (sum[24]) begin
            mant  = sum[24:1];
            exp_r = exp_r + 10'sd1;
         end else begin
            mant = sum[23:0];
         end
      end else begin
         dif = sig_a - sig_b;
         if (dif == '0) return '0;
         for (int unsigned i = 0; i < 24; i++) begin
            if (!found && dif[23-i]) begin
               lz    = 5'(i);
               found = 1'b1;
            end
         end
         mant  = dif << lz;
         exp_r = exp_r - signed'({5'b00000, lz});
      end
      if (exp_r <= 10'sd0) return '0;
      return {a[31], exp_r[7:0], mant[22:0]};
   endfunction

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

   // A row opened from IDLE loads the product verbatim so a lone -0.0 survives.
   assign acc_next = (state_q == S_IDLE) ? bus.in_pprod : fpadd(acc_q, bus.in_pprod);
   assign cnt_next = (state_q == S_IDLE)  ? cnt_bits'(1) :
                     (acc_cnt_q == '1)    ? acc_cnt_q    : acc_cnt_q + cnt_bits'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = bus.in_last ? S_IDLE : S_ACCUM;
      end
   end

   always_comb begin
      acc_d       = acc_q;
      acc_row_d   = acc_row_q;
      acc_cnt_d   = acc_cnt_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_row_d   = out_row_q;
      out_count_d = out_count_q;
      err_d       = err_q;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         acc_d     = acc_next;
         acc_cnt_d = cnt_next;
         if (state_q == S_IDLE) begin
            acc_row_d = bus.in_row;
         end else if (bus.in_row != acc_row_q) begin
            err_d = 1'b1;
         end
         if (bus.in_last) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_next;
            out_row_d   = (state_q == S_IDLE) ? bus.in_row : acc_row_q;
            out_count_d = cnt_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         acc_row_q   <= '0;
         acc_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_row_q   <= '0;
         out_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_row_q   <= acc_row_d;
         acc_cnt_q   <= acc_cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_row_q   <= out_row_d;
         out_count_q <= out_count_d;
         err_q       <= err_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_count = out_count_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_fp_row_accumulator.sv
// Directed-vector bench for fp_row_accumulator with hand-computed FP32 sums.
module tb_fp_row_accumulator;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   fp_row_accumulator_if #(.value_size(32), .row_bits(16), .cnt_bits(16)) bus ();

   fp_row_accumulator #(.value_size(32), .row_bits(16), .cnt_bits(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] p, input logic [15:0] r, input logic l);
      bus.in_valid = 1'b1;
      bus.in_pprod = p;
      bus.in_row   = r;
      bus.in_last  = l;
      step();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic check_result(input string name, input logic [31:0] s,
                               input logic [15:0] r, input logic [15:0] c);
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", name, bus.out_valid); end
      checks++;
      if (bus.out_sum !== s) begin failures++; $display("FAIL %s_sum got=%h exp=%h", name, bus.out_sum, s); end
      checks++;
      if (bus.out_row !== r) begin failures++; $display("FAIL %s_row got=%0d exp=%0d", name, bus.out_row, r); end
      checks++;
      if (bus.out_count !== c) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, bus.out_count, c); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.out_sum !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0", bus.out_sum); end
      checks++;
      if (bus.out_row !== 16'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", bus.out_row); end
      checks++;
      if (bus.out_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.out_count); end
      checks++;
      if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      send(32'h3F800000, 16'd5, 1'b0);
      send(32'h40000000, 16'd5, 1'b0);
      send(32'h3F000000, 16'd5, 1'b1);
      idle();
      check_result("row5", 32'h40600000, 16'd5, 16'd3);
      checks++;
      if (bus.err !== 1'b0) begin failures++; $display("FAIL row5_err got=%b exp=0", bus.err); end
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL row5_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_single_and_cancel();
      send(32'hBF800000, 16'd7, 1'b1);
      idle();
      check_result("row7", 32'hBF800000, 16'd7, 16'd1);
      send(32'h3FC00000, 16'd8, 1'b0);
      send(32'hBFC00000, 16'd8, 1'b1);
      idle();
      check_result("row8_cancel", 32'h00000000, 16'd8, 16'd2);
      send(32'h40000000, 16'd14, 1'b0);
      send(32'hBF800000, 16'd14, 1'b1);
      idle();
      check_result("row14_norm", 32'h3F800000, 16'd14, 16'd2);
      send(32'h3F800000, 16'd15, 1'b0);
      send(32'hC0000000, 16'd15, 1'b1);
      idle();
      check_result("row15_sign", 32'hBF800000, 16'd15, 16'd2);
      step();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      send(32'h40000000, 16'd10, 1'b1);
      idle();
      check_result("bp_first", 32'h40000000, 16'd10, 16'd1);
      bus.in_valid = 1'b1;
      bus.in_pprod = 32'h40400000;
      bus.in_row   = 16'd11;
      bus.in_last  = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", bus.in_ready); end
      step();
      check_result("bp_hold", 32'h40000000, 16'd10, 16'd1);
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_high got=%b exp=1", bus.in_ready); end
      step();
      idle();
      check_result("bp_replace", 32'h40400000, 16'd11, 16'd1);
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_alignment();
      send(32'h3F800000, 16'd12, 1'b0);
      send(32'h33800000, 16'd12, 1'b1);
      idle();
      check_result("trunc", 32'h3F800000, 16'd12, 16'd2);
      send(32'h00000001, 16'd13, 1'b0);
      send(32'h3F800000, 16'd13, 1'b1);
      idle();
      check_result("denorm", 32'h3F800000, 16'd13, 16'd2);
      step();
   endtask

   task automatic test_row_mismatch();
      send(32'h3F800000, 16'd3, 1'b0);
      checks++;
      if (bus.err !== 1'b0) begin failures++; $display("FAIL mm_err_pre got=%b exp=0", bus.err); end
      send(32'h3F800000, 16'd4, 1'b0);
      checks++;
      if (bus.err !== 1'b1) begin failures++; $display("FAIL mm_err_set got=%b exp=1", bus.err); end
      send(32'h40000000, 16'd3, 1'b1);
      idle();
      check_result("mismatch", 32'h40800000, 16'd3, 16'd3);
      step();
      step();
      checks++;
      if (bus.err !== 1'b1) begin failures++; $display("FAIL mm_err_sticky got=%b exp=1", bus.err); end
   endtask

   task automatic test_reset_mid_row();
      send(32'h3F800000, 16'd2, 1'b0);
      send(32'h3F800000, 16'd2, 1'b0);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.out_sum !== 32'h0) begin failures++; $display("FAIL mid_rst_sum got=%h exp=0", bus.out_sum); end
      checks++;
      if (bus.out_count !== 16'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", bus.out_count); end
      checks++;
      if (bus.err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b exp=0", bus.err); end
      send(32'h40400000, 16'd9, 1'b1);
      idle();
      check_result("after_rst", 32'h40400000, 16'd9, 16'd1);
      step();
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_pprod  = '0;
      bus.in_row    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_back_to_back();
      test_single_and_cancel();
      test_backpressure();
      test_alignment();
      test_row_mismatch();
      test_reset_mid_row();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
